intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
- Memory-mapped interrupt controller between external interrupt sources and CP0's HWInt inputs.
- Latches up to NSRC request lines as pending bits; each line is edge- or level-triggered.
- Per-source masking; the masked pending vector drives HWInt.
- The exception handler acknowledges by storing to BASE+0 (0x7f20), which clears pending bits and records overruns.
- Sits on the CPU's M-stage data bus beside the bridge decode for DM and the timers.

Parameters:
- BASE, 32'h00007f20, word-aligned base address; the block occupies BASE..BASE+0xF.
- NSRC, 6, number of interrupt sources; range 1..6.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- irq_in, input, NSRC, raw interrupt request lines, synchronous to clk.
- m_addr, input, 32, M-stage data address.
- m_byteen, input, 4, store byte enables; 0 means no write.
- m_wdata, input, 32, store data.
- m_rdata, output, 32, combinational read data for the addressed register; 0 when outside the window.
- hwint, output, NSRC, pending & mask; goes to CP0 HWInt[NSRC-1:0].

Behaviour:
- Reset: synchronous, active-high; clk and reset named as in the rest of the design.
  - pend=0, mask=0, mode=0 (level), ovr=0, irq_prev=0.
  - hwint=0 the cycle after reset is sampled.
- Address decode: sel = (m_addr & ~3) in BASE..BASE+0xC. Offsets:
  - +0 ACK: write-only; reads return 0.
  - +4 MASK: rw, bits [NSRC-1:0].
  - +8 MODE: rw, 1=edge, 0=level.
  - +C STAT: read-only.
- STAT layout:
  - [5:0] = pend.
  - [13:8] = ovr.
  - [18:16] = index of the highest-numbered bit set in hwint; 3'd7 if hwint==0.
  - All other bits 0.
- Writes: happen only when sel and |m_byteen.
  - MASK/MODE update from m_wdata[NSRC-1:0] only if m_byteen[0]; otherwise ignored.
  - Writes to STAT are ignored.
- ACK write, with any nonzero byteen:
  - clr = (m_byteen[0] && m_wdata[NSRC-1:0]!=0) ? m_wdata[NSRC-1:0] : all-ones.
  - Takes effect on pend and ovr at the same posedge.
- Edge source i (mode[i]=1):
  - rise_i = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle.
  - pend[i] next = rise_i | (pend[i] & ~clr[i]). Set wins over simultaneous clear.
  - ovr[i] next = (rise_i & pend[i] & ~clr[i]) | (ovr[i] & ~clr[i]).
- Level source i (mode[i]=0):
  - pend[i] <= irq_in[i] each cycle; ACK has no lasting effect on pend[i] but still clears ovr[i].
  - ovr[i] never sets.
- Mode switch level→edge: pend[i] keeps its current value; irq_prev prevents a false edge if the line is already high.
- Latency:
  - irq_in rises before posedge t → pend/hwint high after posedge t.
  - ACK sampled at posedge t → hwint low after t, unless re-set.
- hwint is combinational AND of registered pend and mask; no combinational path from irq_in or the bus.
- The mask does not gate latching: masked sources still accumulate pend and ovr.
- Reset mid-operation clears all state regardless of concurrent bus writes.

Test Plan:
- Reset, then MASK=0x3F, MODE=0x3F; pulse irq_in[2] for 1 cycle → hwint=0x04 from the next edge, STAT=0x0002_0004; sb $0 to 0x7f20 → hwint=0 next cycle, STAT=0x0007_0000.
- Edge mode, mask=0x01; irq_in[0] pulses twice without ACK → pend[0]=1, STAT[8]=1; ACK with wdata=0x01 → STAT=0x0007_0000.
- Level mode, mask=0x08; hold irq_in[3]=1 and ACK with byteen=4'b1111, wdata=0 → hwint stays 0x08; drop irq_in[3] → hwint=0 after one edge.
- Edge mode; rising edge on irq_in[1] in the same cycle as an ACK clearing bit 1 → pend[1]=1, ovr[1]=0 afterwards.
- MASK=0; pulse irq_in[5] → hwint=0, STAT[5]=1; write MASK=0x20 → hwint=0x20 the next cycle, STAT[18:16]=5.
- Store with byteen=4'b0010 to 0x7f24 → MASK unchanged; read of 0x7f30 → m_rdata=0; reset asserted during an ACK store → all state 0.

Source files
------------

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller feeding CP0 HWInt.
// Latches edge/level requests, masks them, and is acknowledged by a bus store.
module intr_ctrl #(
    parameter logic [31:0] BASE = 32'h00007f20,
    parameter int          NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [31:0]     m_addr,
    input  logic [3:0]      m_byteen,
    input  logic [31:0]     m_wdata,
    output logic [31:0]     m_rdata,
    output logic [NSRC-1:0] hwint
);

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] ovr;
    logic [NSRC-1:0] irq_prev;

    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] ovr_nxt;

    logic [31:0] addr_w;
    logic [1:0]  off;
    logic        sel;
    logic        wr;
    logic        ack_wr;
    logic        mask_wr;
    logic        mode_wr;
    logic [2:0]  hi_idx;
    logic [31:0] stat;

    // Low address bits and upper data bits are not decoded.
    logic unused_bits;
    assign unused_bits = ^{m_addr[1:0], m_wdata[31:NSRC]};

    assign addr_w  = {m_addr[31:2], 2'b00};
    assign sel     = (addr_w >= BASE) && (addr_w <= BASE + 32'hC);
    assign off     = m_addr[3:2] - BASE[3:2];
    assign wr      = sel && (|m_byteen);
    assign ack_wr  = wr && (off == 2'd0);
    assign mask_wr = wr && m_byteen[0] && (off == 2'd1);
    assign mode_wr = wr && m_byteen[0] && (off == 2'd2);

    // An ACK with no usable low-byte data clears every source.
    always_comb begin
        clr = '0;
        if (ack_wr) begin
            if (m_byteen[0] && (|m_wdata[NSRC-1:0]))
                clr = m_wdata[NSRC-1:0];
            else
                clr = '1;
        end
    end

    // Edge sources set over a simultaneous clear; level sources track the line.
    assign rise     = irq_in & ~irq_prev;
    assign pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & irq_in);
    assign ovr_nxt  = (mode & rise & pend & ~clr) | (ovr & ~clr);

    // Register update; masked sources still latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= '0;
            mask     <= '0;
            mode     <= '0;
            ovr      <= '0;
            irq_prev <= '0;
        end else begin
            pend     <= pend_nxt;
            ovr      <= ovr_nxt;
            irq_prev <= irq_in;
            if (mask_wr)
                mask <= m_wdata[NSRC-1:0];
            if (mode_wr)
                mode <= m_wdata[NSRC-1:0];
        end
    end

    assign hwint = pend & mask;

    // Highest-numbered active interrupt, 7 when none.
    always_comb begin
        hi_idx = 3'd7;
        for (int i = 0; i < NSRC; i++) begin
            if (hwint[i])
                hi_idx = 3'(i);
        end
    end

    // Status word assembly.
    always_comb begin
        stat = '0;
        stat[NSRC-1:0]   = pend;
        stat[8 +: NSRC]  = ovr;
        stat[18:16]      = hi_idx;
    end

    // Read mux; ACK slot and out-of-window addresses read zero.
    always_comb begin
        m_rdata = '0;
        if (sel) begin
            unique case (off)
                2'd0: m_rdata = '0;
                2'd1: m_rdata = {{(32-NSRC){1'b0}}, mask};
                2'd2: m_rdata = {{(32-NSRC){1'b0}}, mode};
                2'd3: m_rdata = stat;
                default: m_rdata = '0;
            endcase
        end
    end

endmodule
